intr_gateway: RTL
=================

# intr_gateway

Interrupt gateway and priority selector that consumes the per-peripheral `intr_o` vectors produced by the peripheral interrupt register logic. It:
- converts level or edge sources into single pending requests;
- holds each source off while software services it;
- presents the highest-priority eligible request to the core as a registered IRQ and ID with a claim/complete handshake.

It sits between the peripheral interrupt outputs and the core's external interrupt input.

## Interface
Parameters:
- `N_SOURCE`, 8: number of interrupt sources (1..63).
- `PRIO_W`, 2: priority field width per source.
- `ID_W`, `$clog2(N_SOURCE+1)`: derived, not overridable; ID 0 means "no interrupt".

Ports:
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset; one clock, asynchronous, active-low.
- `src_i`  in  N_SOURCE  raw interrupt lines (peripheral `intr_o`).
- `le_i`  in  N_SOURCE  per source: 1 = edge-triggered, 0 = level.
- `prio_i`  in  N_SOURCE*PRIO_W  per-source priority; source k at bits [k*PRIO_W +: PRIO_W].
- `threshold_i`  in  PRIO_W  only priorities strictly greater than this are signalled.
- `claim_i`  in  1  single-cycle claim of the ID currently on `irq_id_o`.
- `complete_i`  in  1  single-cycle completion strobe.
- `complete_id_i`  in  ID_W  ID being completed.
- `ip_o`  out  N_SOURCE  pending bits.
- `irq_o`  out  1  interrupt request to the core.
- `irq_id_o`  out  ID_W  ID of the selected source, index+1; 0 when none.

## Operation
Per-source state is two flops, `ip` (pending) and `ia` (active/in-flight), plus `src_q`, the previous `src_i` used for edge detection.

Legal states:
- IDLE: ia=0, ip=0.
- PENDING: ia=1, ip=1.
- CLAIMED: ia=1, ip=0.

Transitions for source k:
- IDLE→PENDING when `req[k]`, where `req[k] = le_i[k] ? (src_i[k] & ~src_q[k]) : src_i[k]`.
- PENDING→CLAIMED when `claim_i` and `irq_id_o == k+1`.
- CLAIMED→IDLE when `complete_i` and `complete_id_i == k+1`.

Ignored events:
- Requests while ia=1. Edges arriving during PENDING or CLAIMED are dropped, not queued.
- Complete with ID 0, ID > N_SOURCE, or ID of a source not in CLAIMED. A source in PENDING is not completed.
- Claim while `irq_id_o == 0`.

Level sources re-pend on the cycle after complete if `src_i` is still high.

Selection:
- Eligible means ip=1 and prio > `threshold_i`. Priority 0 never interrupts.
- The highest priority wins; on a tie, the lowest index wins.
- `irq_o` and `irq_id_o` are registered from the selection result.
- `ip_o` equals the `ip` register.
- Changes to `le_i`, `prio_i` or `threshold_i` take effect on the next selection evaluation. They never clear `ip` or `ia`.

## Timing
- Reset values: `ip`, `ia` and `src_q` all 0; `irq_o` 0; `irq_id_o` 0; `ip_o` 0.
- Reset asserted mid-service clears all state immediately; in-flight claims are lost.
- Latency:
  - A `src_i` rise sampled at edge n sets `ip` at edge n; visible on `ip_o` in cycle n+1.
  - `irq_o` and `irq_id_o` update at edge n+1.
  - Total: 2 cycles from the source to the IRQ.
- Claim at edge n clears `ip` at edge n. `irq_o`/`irq_id_o` reflect the next winner, or 0, after edge n+1.
- The core must not issue a second claim in cycle n+1. `irq_id_o` is stale for one cycle after a claim.
- Complete at edge n clears `ia` at edge n. A level source still asserted sets `ip` at edge n+1.
- Claim and complete in the same cycle on different IDs are both honoured. On the same ID, only the claim takes effect, because the source is PENDING at that edge.

## Structure
- Package `intr_gateway_pkg`:
  - a `prio_t` typedef parameterised by default `PRIO_W`;
  - an `ID_NONE = 0` constant;
  - the ID-width helper function.
- Sub-module `intr_prio_tree`: a combinational binary max-tree over {eligible, prio, id}. Ties resolve to the left (lower index). Outputs are the winner ID and a valid flag.
- The top level holds the gateway flops, edge detect, and output registers.

## Test plan
- Level source 3 (prio 2, threshold 0) held high → `irq_o`=1, `irq_id_o`=4 two cycles later. After claim, the ID reads 0. After complete with ID 4 and src still high, `ip_o[3]` re-sets one cycle later.
- Edge source 1 pulsed three times during CLAIMED → no new pending. After complete, the next pulse → `irq_id_o`=2.
- Sources 2 and 5, both prio 3, asserted together → ID 3 first. After claim, ID 6 appears.
- Threshold 2 with source 0 at prio 2 asserted → `irq_o` stays 0. Lowering threshold to 1 → `irq_id_o`=1.
- Complete with ID 0, ID 9 (N_SOURCE=8), and the ID of a PENDING source → no state change on `ip_o` or `irq_id_o`.
- Reset asserted while source 4 is CLAIMED → all outputs 0 immediately. After release, a level-high source 4 re-pends within 2 cycles.

Source files
------------

// File: rtl/intr_gateway_pkg.sv
// Shared types and helpers for the interrupt gateway.
// Latency: n/a (declarations only).
// Backpressure: n/a.
`timescale 1ns/1ps
package intr_gateway_pkg;

   localparam int PRIO_W_DEF = 2;

   // ID 0 is reserved to mean "no interrupt"; source k reports as k+1.
   localparam int ID_NONE = 0;

   typedef logic [PRIO_W_DEF-1:0] prio_t;

   // Enough bits to hold IDs 0..n_source.
   function automatic int id_width(input int n_source);
      return $clog2(n_source + 1);
   endfunction

endpackage

// File: rtl/intr_prio_tree.sv
// Combinational max-tree picking the highest-priority eligible source, lowest index on ties.
// Latency: zero cycles (purely combinational).
// Backpressure: none; the result follows the inputs every cycle.
`timescale 1ns/1ps
module intr_prio_tree
   import intr_gateway_pkg::*;
#(
   parameter int N_SOURCE = 8,
   parameter int PRIO_W   = 2,
   parameter int ID_W     = 4
) (
   input  logic [N_SOURCE-1:0]        eligible,
   input  logic [N_SOURCE*PRIO_W-1:0] prio,
   output logic [ID_W-1:0]            id,
   output logic                       vld
);

   // Pad the leaf count up to a power of two; padding leaves are never eligible.
   localparam int LEVELS = (N_SOURCE > 1) ? $clog2(N_SOURCE) : 0;
   localparam int N_LEAF = 1 << LEVELS;
   localparam int N_NODE = 2 * N_LEAF - 1;

   logic [N_LEAF-1:0]        elig_pad;
   logic [N_LEAF*PRIO_W-1:0] prio_pad;

   // Heap layout: node j has children 2j+1 (lower indices) and 2j+2, leaves start at N_LEAF-1.
   logic              node_vld  [N_NODE];
   logic [PRIO_W-1:0] node_prio [N_NODE];
   logic [ID_W-1:0]   node_id   [N_NODE];

   assign elig_pad = N_LEAF'(eligible);
   assign prio_pad = (N_LEAF*PRIO_W)'(prio);

   // Fill the leaves, then reduce bottom-up; the left child wins unless the right is strictly higher.
   always_comb begin
      logic pick_left;
      pick_left = 1'b0;
      for (int i = 0; i < N_LEAF; i++) begin
         node_vld[N_LEAF-1+i]  = elig_pad[i];
         node_prio[N_LEAF-1+i] = prio_pad[i*PRIO_W +: PRIO_W];
         node_id[N_LEAF-1+i]   = ID_W'(i + 1);
      end
      for (int j = N_LEAF - 2; j >= 0; j--) begin
         pick_left = node_vld[2*j+1] &&
                     (!node_vld[2*j+2] || (node_prio[2*j+1] >= node_prio[2*j+2]));
         node_vld[j]  = node_vld[2*j+1] | node_vld[2*j+2];
         node_prio[j] = pick_left ? node_prio[2*j+1] : node_prio[2*j+2];
         node_id[j]   = pick_left ? node_id[2*j+1]   : node_id[2*j+2];
      end
   end

   assign vld = node_vld[0];
   assign id  = node_vld[0] ? node_id[0] : ID_W'(ID_NONE);

endmodule

// File: rtl/intr_gateway.sv
// Interrupt gateway: level/edge sources to single pending requests, held off while in service.
// Latency: source rise -> ip_o next cycle -> irq_o/irq_id_o one cycle after that (2 cycles).
// Backpressure: none; sources are held off via the claim/complete handshake, extra edges are dropped.
`timescale 1ns/1ps
module intr_gateway
   import intr_gateway_pkg::*;
#(
   parameter  int N_SOURCE = 8,
   parameter  int PRIO_W   = 2,
   localparam int ID_W     = id_width(N_SOURCE)
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic [N_SOURCE-1:0]        src_i,
   input  logic [N_SOURCE-1:0]        le_i,
   input  logic [N_SOURCE*PRIO_W-1:0] prio_i,
   input  logic [PRIO_W-1:0]          threshold_i,
   input  logic                       claim_i,
   input  logic                       complete_i,
   input  logic [ID_W-1:0]            complete_id_i,
   output logic [N_SOURCE-1:0]        ip_o,
   output logic                       irq_o,
   output logic [ID_W-1:0]            irq_id_o
);

   // Per source: IDLE (ia=0, ip=0), PENDING (ia=1, ip=1), CLAIMED (ia=1, ip=0).
   logic [N_SOURCE-1:0] ip, ia, src_q;
   logic [N_SOURCE-1:0] ip_nxt, ia_nxt;
   logic [N_SOURCE-1:0] req, eligible, claim_hit, complete_hit;
   logic [ID_W-1:0]     sel_id;
   logic                sel_vld;

   // Decode requests, eligibility and which source a claim or complete targets.
   always_comb begin
      req          = '0;
      eligible     = '0;
      claim_hit    = '0;
      complete_hit = '0;
      for (int k = 0; k < N_SOURCE; k++) begin
         req[k]          = le_i[k] ? (src_i[k] & ~src_q[k]) : src_i[k];
         eligible[k]     = ip[k] && (prio_i[k*PRIO_W +: PRIO_W] > threshold_i);
         // A claim only lands on a PENDING source; ID 0 never matches any k+1.
         claim_hit[k]    = claim_i && ip[k] && (irq_id_o == ID_W'(k + 1));
         // A complete only lands on a CLAIMED source, so a same-cycle claim on the same ID wins.
         complete_hit[k] = complete_i && ia[k] && !ip[k] && (complete_id_i == ID_W'(k + 1));
      end
   end

   // Next state: requests only enter from IDLE, so anything arriving while active is dropped.
   always_comb begin
      ip_nxt = (ip & ~claim_hit)    | (~ia & req);
      ia_nxt = (ia & ~complete_hit) | (~ia & req);
   end

   intr_prio_tree #(
      .N_SOURCE (N_SOURCE),
      .PRIO_W   (PRIO_W),
      .ID_W     (ID_W)
   ) u_prio_tree (
      .eligible (eligible),
      .prio     (prio_i),
      .id       (sel_id),
      .vld      (sel_vld)
   );

   // Gateway flops and edge-detect history.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ip    <= '0;
         ia    <= '0;
         src_q <= '0;
      end else begin
         ip    <= ip_nxt;
         ia    <= ia_nxt;
         src_q <= src_i;
      end
   end

   // Registered request to the core; irq_id_o is stale for one cycle after a claim.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         irq_o    <= 1'b0;
         irq_id_o <= ID_W'(ID_NONE);
      end else begin
         irq_o    <= sel_vld;
         irq_id_o <= sel_id;
      end
   end

   assign ip_o = ip;

endmodule
